// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, READ_WAIT = 1'b1} state_e;
  typedef enum logic [0:0] {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/memory_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// master = core requesters plus memory model, slave = arbiter.
interface memory_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_read_data,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_write_en, mem_address, mem_write_data, mem_funct3
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_read_data,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_write_en, mem_address, mem_write_data, mem_funct3
  );
endinterface

// File: rtl/memory_port_arbiter_picker.sv
// Winner selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic i_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_gnt_if,
  output logic o_gnt_d
);
  logic w_d_first;
  logic w_gnt_if;
  logic w_gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_prio names the requester that wins the next tie.
  owner_e r_prio;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= OWN_D;
    end else if (w_gnt_d) begin
      r_prio <= OWN_IF;
    end else if (w_gnt_if) begin
      r_prio <= OWN_D;
    end
  end

  assign w_d_first = (r_prio == OWN_D);
`else
  assign w_d_first = 1'b1;
`endif

  assign w_gnt_d  = i_en & i_d_req & (w_d_first | ~i_if_req);
  assign w_gnt_if = i_en & i_if_req & ~w_gnt_d;
  assign o_gnt_d  = w_gnt_d;
  assign o_gnt_if = w_gnt_if;
endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Optional round-robin arbitration via MEM_ARB_ROUND_ROBIN_EN (see picker).
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  memory_port_arbiter_if.slave  bus
);
  localparam logic [0:0] S_IDLE      = IDLE;
  localparam logic [0:0] S_READ_WAIT = READ_WAIT;
  localparam logic [1:0] CNT_LOAD    = 2'(READ_LATENCY - 1);

  logic [0:0]  r_state;
  owner_e      r_owner;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [1:0]  r_cnt;

  logic w_en;
  logic w_gnt_if;
  logic w_gnt_d;
  logic w_read_gnt;
  logic w_done;
  logic w_if_rvalid;
  logic w_d_rvalid;

  assign w_en = rst_n & (r_state == S_IDLE);

  mem_arb_picker u_picker (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .i_en     (w_en),
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .o_gnt_if (w_gnt_if),
    .o_gnt_d  (w_gnt_d)
  );

  assign w_read_gnt = w_gnt_if | (w_gnt_d & ~bus.d_we);
  assign w_done     = rst_n & (r_state == S_READ_WAIT) & (r_cnt == 2'd0);

  assign w_if_rvalid = w_done & (r_owner == OWN_IF);
  assign w_d_rvalid  = w_done & (r_owner == OWN_D);

  assign bus.if_gnt    = w_gnt_if;
  assign bus.d_gnt     = w_gnt_d;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_read_data : 32'd0;
  assign bus.d_rdata   = w_d_rvalid  ? bus.mem_read_data : 32'd0;

  always_comb begin
    bus.mem_write_en   = 1'b0;
    bus.mem_address    = 32'd0;
    bus.mem_write_data = 32'd0;
    bus.mem_funct3     = 3'd0;
    if (w_gnt_d) begin
      bus.mem_address = bus.d_addr;
      bus.mem_funct3  = bus.d_funct3;
      if (bus.d_we) begin
        bus.mem_write_en   = 1'b1;
        bus.mem_write_data = bus.d_wdata;
      end
    end else if (w_gnt_if) begin
      bus.mem_address = bus.if_addr;
      bus.mem_funct3  = FUNCT3_WORD;
    end else if (rst_n && (r_state == S_READ_WAIT)) begin
      bus.mem_address = r_addr;
      bus.mem_funct3  = r_funct3;
    end
  end

  // Stores complete in the grant cycle; only reads occupy the port afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_IF;
      r_addr   <= 32'd0;
      r_funct3 <= 3'd0;
      r_cnt    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_read_gnt) begin
            r_state  <= S_READ_WAIT;
            r_owner  <= w_gnt_d ? OWN_D : OWN_IF;
            r_addr   <= w_gnt_d ? bus.d_addr : bus.if_addr;
            r_funct3 <= w_gnt_d ? bus.d_funct3 : FUNCT3_WORD;
            r_cnt    <= CNT_LOAD;
          end
        end
        default: begin
          if (r_cnt == 2'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 3) against a cycle-level reference model.
module tb_memory_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [1:0]  t_if_req, t_d_req, t_d_we;
  logic [31:0] t_if_addr [2];
  logic [31:0] t_d_addr [2];
  logic [31:0] t_d_wdata [2];
  logic [31:0] t_mrd [2];
  logic [2:0]  t_d_f3 [2];

  logic [1:0]  a_if_gnt, a_d_gnt, a_if_rv, a_d_rv, a_we;
  logic [31:0] a_if_rdata [2];
  logic [31:0] a_d_rdata [2];
  logic [31:0] a_addr [2];
  logic [31:0] a_wdata [2];
  logic [2:0]  a_f3 [2];

  memory_port_arbiter_if bus1();
  memory_port_arbiter_if bus3();

  memory_port_arbiter #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  memory_port_arbiter #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  assign bus1.if_req = t_if_req[0];   assign bus3.if_req = t_if_req[1];
  assign bus1.if_addr = t_if_addr[0]; assign bus3.if_addr = t_if_addr[1];
  assign bus1.d_req = t_d_req[0];     assign bus3.d_req = t_d_req[1];
  assign bus1.d_we = t_d_we[0];       assign bus3.d_we = t_d_we[1];
  assign bus1.d_addr = t_d_addr[0];   assign bus3.d_addr = t_d_addr[1];
  assign bus1.d_wdata = t_d_wdata[0]; assign bus3.d_wdata = t_d_wdata[1];
  assign bus1.d_funct3 = t_d_f3[0];   assign bus3.d_funct3 = t_d_f3[1];
  assign bus1.mem_read_data = t_mrd[0]; assign bus3.mem_read_data = t_mrd[1];

  assign a_if_gnt[0] = bus1.if_gnt;      assign a_if_gnt[1] = bus3.if_gnt;
  assign a_d_gnt[0] = bus1.d_gnt;        assign a_d_gnt[1] = bus3.d_gnt;
  assign a_if_rv[0] = bus1.if_rvalid;    assign a_if_rv[1] = bus3.if_rvalid;
  assign a_d_rv[0] = bus1.d_rvalid;      assign a_d_rv[1] = bus3.d_rvalid;
  assign a_we[0] = bus1.mem_write_en;    assign a_we[1] = bus3.mem_write_en;
  assign a_if_rdata[0] = bus1.if_rdata;  assign a_if_rdata[1] = bus3.if_rdata;
  assign a_d_rdata[0] = bus1.d_rdata;    assign a_d_rdata[1] = bus3.d_rdata;
  assign a_addr[0] = bus1.mem_address;   assign a_addr[1] = bus3.mem_address;
  assign a_wdata[0] = bus1.mem_write_data; assign a_wdata[1] = bus3.mem_write_data;
  assign a_f3[0] = bus1.mem_funct3;      assign a_f3[1] = bus3.mem_funct3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a read granted in cycle c owns the port through cycle c+latency.
  int          rl [2]     = '{1, 3};
  int          rv_at [2]  = '{-1, -1};
  logic        m_own_d [2] = '{1'b0, 1'b0};
  logic [31:0] m_addr [2]  = '{32'd0, 32'd0};
  logic [2:0]  m_f3 [2]    = '{3'd0, 3'd0};
  logic        prio_d [2]  = '{1'b1, 1'b1};
  int          cyc = 0;
  logic [1:0]  seen_if_gnt = 2'b00;
  logic [1:0]  seen_d_gnt = 2'b00;

  always @(negedge clk) begin
    logic e_ig, e_dg, e_ir, e_dr, e_we, d_first;
    logic [31:0] e_ird, e_drd, e_addr, e_wd;
    logic [2:0] e_f3;
    for (int k = 0; k < 2; k++) begin
      {e_ig, e_dg, e_ir, e_dr, e_we} = 5'b0;
      e_ird = 0; e_drd = 0; e_addr = 0; e_wd = 0; e_f3 = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      d_first = prio_d[k];
`else
      d_first = 1'b1;
`endif
      if (!rst_n) begin
        rv_at[k] = -1;
        prio_d[k] = 1'b1;
      end else if (rv_at[k] >= 0) begin
        e_addr = m_addr[k];
        e_f3 = m_f3[k];
        if (cyc == rv_at[k]) begin
          if (m_own_d[k]) begin e_dr = 1'b1; e_drd = t_mrd[k]; end
          else begin e_ir = 1'b1; e_ird = t_mrd[k]; end
          rv_at[k] = -1;
        end
      end else if (t_d_req[k] && (d_first || !t_if_req[k])) begin
        e_dg = 1'b1; e_addr = t_d_addr[k]; e_f3 = t_d_f3[k];
        if (t_d_we[k]) begin
          e_we = 1'b1; e_wd = t_d_wdata[k];
        end else begin
          rv_at[k] = cyc + rl[k]; m_own_d[k] = 1'b1; m_addr[k] = t_d_addr[k]; m_f3[k] = t_d_f3[k];
        end
        prio_d[k] = 1'b0;
      end else if (t_if_req[k]) begin
        e_ig = 1'b1; e_addr = t_if_addr[k]; e_f3 = 3'b010;
        rv_at[k] = cyc + rl[k]; m_own_d[k] = 1'b0; m_addr[k] = t_if_addr[k]; m_f3[k] = 3'b010;
        prio_d[k] = 1'b1;
      end
      chk($sformatf("m%0d_if_gnt c%0d", k, cyc), {31'd0, a_if_gnt[k]}, {31'd0, e_ig});
      chk($sformatf("m%0d_d_gnt c%0d", k, cyc), {31'd0, a_d_gnt[k]}, {31'd0, e_dg});
      chk($sformatf("m%0d_if_rvalid c%0d", k, cyc), {31'd0, a_if_rv[k]}, {31'd0, e_ir});
      chk($sformatf("m%0d_d_rvalid c%0d", k, cyc), {31'd0, a_d_rv[k]}, {31'd0, e_dr});
      chk($sformatf("m%0d_if_rdata c%0d", k, cyc), a_if_rdata[k], e_ird);
      chk($sformatf("m%0d_d_rdata c%0d", k, cyc), a_d_rdata[k], e_drd);
      chk($sformatf("m%0d_we c%0d", k, cyc), {31'd0, a_we[k]}, {31'd0, e_we});
      chk($sformatf("m%0d_addr c%0d", k, cyc), a_addr[k], e_addr);
      chk($sformatf("m%0d_wdata c%0d", k, cyc), a_wdata[k], e_wd);
      chk($sformatf("m%0d_funct3 c%0d", k, cyc), {29'd0, a_f3[k]}, {29'd0, e_f3});
      seen_if_gnt[k] = a_if_gnt[k];
      seen_d_gnt[k] = a_d_gnt[k];
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t_if_req = 2'b00; t_d_req = 2'b00; t_d_we = 2'b00;
    for (int k = 0; k < 2; k++) begin
      t_if_addr[k] = 0; t_d_addr[k] = 0; t_d_wdata[k] = 0; t_d_f3[k] = 0; t_mrd[k] = 0;
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("reset_if_gnt", {31'd0, a_if_gnt[0]}, 32'd0);
    chk("reset_addr", a_addr[1], 32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("idle_addr", a_addr[0], 32'd0);

    // Fetch only, latency 1
    step(); t_if_req[0] = 1'b1; t_if_addr[0] = 32'h100; t_mrd[0] = 32'h0050_0093;
    @(negedge clk);
    chk("fetch_gnt", {31'd0, a_if_gnt[0]}, 32'd1);
    chk("fetch_addr", a_addr[0], 32'h100);
    chk("fetch_f3", {29'd0, a_f3[0]}, 32'd2);
    step(); t_if_req[0] = 1'b0;
    @(negedge clk);
    chk("fetch_rvalid", {31'd0, a_if_rv[0]}, 32'd1);
    chk("fetch_rdata", a_if_rdata[0], 32'h0050_0093);

    // Store with a fetch waiting behind it
    step(); t_d_req[0] = 1'b1; t_d_we[0] = 1'b1; t_d_addr[0] = 32'h200; t_d_wdata[0] = 32'hDEAD_BEEF;
    t_d_f3[0] = 3'b010; t_if_req[0] = 1'b1; t_if_addr[0] = 32'h108;
    @(negedge clk);
    chk("store_gnt", {31'd0, a_d_gnt[0]}, 32'd1);
    chk("store_we", {31'd0, a_we[0]}, 32'd1);
    chk("store_wdata", a_wdata[0], 32'hDEAD_BEEF);
    step(); t_d_req[0] = 1'b0; t_d_we[0] = 1'b0;
    @(negedge clk);
    chk("after_store_if_gnt", {31'd0, a_if_gnt[0]}, 32'd1);
    chk("after_store_we", {31'd0, a_we[0]}, 32'd0);
    chk("store_no_rvalid", {31'd0, a_d_rv[0]}, 32'd0);
    step(); t_if_req[0] = 1'b0;
    @(negedge clk);

    // Simultaneous load and fetch
    step(); t_d_req[0] = 1'b1; t_d_addr[0] = 32'h204; t_if_req[0] = 1'b1; t_if_addr[0] = 32'h104;
    t_mrd[0] = 32'h1122_3344;
    @(negedge clk);
    chk("sim_d_gnt", {31'd0, a_d_gnt[0]}, 32'd1);
    chk("sim_addr", a_addr[0], 32'h204);
    step(); t_d_req[0] = 1'b0;
    @(negedge clk);
    chk("sim_d_rvalid", {31'd0, a_d_rv[0]}, 32'd1);
    chk("sim_d_rdata", a_d_rdata[0], 32'h1122_3344);
    chk("sim_no_if_gnt", {31'd0, a_if_gnt[0]}, 32'd0);
    step();
    @(negedge clk);
    chk("sim_if_gnt", {31'd0, a_if_gnt[0]}, 32'd1);
    chk("sim_if_addr", a_addr[0], 32'h104);
    step(); t_if_req[0] = 1'b0;
    @(negedge clk);

    // Both requesters held continuously (stores and fetches)
    step(); t_d_req[0] = 1'b1; t_d_we[0] = 1'b1; t_d_addr[0] = 32'h208; t_d_wdata[0] = 32'd1;
    t_if_req[0] = 1'b1; t_if_addr[0] = 32'h10C;
    @(negedge clk); chk("held_1st_d", {31'd0, a_d_gnt[0]}, 32'd1);
    step(); t_d_wdata[0] = 32'd2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    @(negedge clk); chk("rr_2nd_if", {31'd0, a_if_gnt[0]}, 32'd1);
    step();
    @(negedge clk); chk("rr_rvalid", {31'd0, a_if_rv[0]}, 32'd1);
    step();
    @(negedge clk); chk("rr_3rd_d", {31'd0, a_d_gnt[0]}, 32'd1);
`else
    @(negedge clk); chk("fp_2nd_d", {31'd0, a_d_gnt[0]}, 32'd1);
    step(); t_d_wdata[0] = 32'd3;
    @(negedge clk); chk("fp_3rd_d", {31'd0, a_d_gnt[0]}, 32'd1);
`endif
    step(); t_d_req[0] = 1'b0; t_d_we[0] = 1'b0; t_if_req[0] = 1'b0;
    repeat (2) step();

    // Latency 3 load with a pending fetch
    t_mrd[1] = 32'hCAFE_F00D; t_d_req[1] = 1'b1; t_d_addr[1] = 32'h300; t_d_f3[1] = 3'b100;
    t_if_req[1] = 1'b1; t_if_addr[1] = 32'h310;
    @(negedge clk);
    chk("l3_d_gnt", {31'd0, a_d_gnt[1]}, 32'd1);
    chk("l3_f3", {29'd0, a_f3[1]}, 32'd4);
    step(); t_d_req[1] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("l3_addr_T%0d", i), a_addr[1], 32'h300);
      chk($sformatf("l3_rvalid_T%0d", i), {31'd0, a_d_rv[1]}, (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("l3_no_if_gnt_T%0d", i), {31'd0, a_if_gnt[1]}, 32'd0);
      if (i < 3) step();
    end
    chk("l3_rdata", a_d_rdata[1], 32'hCAFE_F00D);
    step();
    @(negedge clk);
    chk("l3_if_gnt_T4", {31'd0, a_if_gnt[1]}, 32'd1);
    step(); t_if_req[1] = 1'b0;
    repeat (3) step();

    // Reset one cycle into a latency 3 read
    t_d_req[1] = 1'b1; t_d_addr[1] = 32'h320; t_d_f3[1] = 3'b010;
    @(negedge clk); chk("rst_rd_gnt", {31'd0, a_d_gnt[1]}, 32'd1);
    step(); t_d_req[1] = 1'b0; rst_n = 1'b0;
    @(negedge clk); chk("rst_rd_addr", a_addr[1], 32'd0);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rvalid_%0d", i), {31'd0, a_d_rv[1]}, 32'd0);
      chk($sformatf("rst_addr0_%0d", i), a_addr[1], 32'd0);
      step();
    end
    t_if_req[1] = 1'b1; t_if_addr[1] = 32'h330;
    @(negedge clk); chk("rst_idle_gnt", {31'd0, a_if_gnt[1]}, 32'd1);
    step(); t_if_req[1] = 1'b0;
    repeat (4) step();

    // Randomized traffic, protocol-respecting requesters
    for (int n = 0; n < 4000; n++) begin
      step();
      rst_n = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 2; k++) begin
        t_mrd[k] = $urandom;
        if (!t_if_req[k] || seen_if_gnt[k]) begin
          t_if_req[k] = ($urandom_range(0, 2) != 0);
          t_if_addr[k] = $urandom & 32'hFFFF_FFFC;
        end else if ($urandom_range(0, 15) == 0) begin
          t_if_req[k] = 1'b0;
        end
        if (!t_d_req[k] || seen_d_gnt[k]) begin
          t_d_req[k] = ($urandom_range(0, 2) != 0);
          t_d_we[k] = $urandom_range(0, 1) != 0;
          t_d_addr[k] = $urandom;
          t_d_wdata[k] = $urandom;
          t_d_f3[k] = 3'($urandom_range(0, 7));
        end else if ($urandom_range(0, 15) == 0) begin
          t_d_req[k] = 1'b0;
        end
      end
    end
    step(); rst_n = 1'b1; idle_inputs();
    repeat (6) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the core's single unified memory port between two requesters: the instruction-fetch path, which reads the instruction word at `pc`, and the load/store data path, which reads or writes at the ALU-computed address. The arbiter accepts requests through a req/gnt handshake, tracks the fixed memory read latency with a counter, and returns read data through a one-cycle `rvalid` strobe. It sits between the control unit / datapath and the memory module. Load sign/zero extension stays in the datapath and is not done here.

## Interface
- `READ_LATENCY`, default 1: cycles from read address presentation to valid `mem_read_data`. Legal range 1..3.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `if_req`  in  1  fetch request; held high until `if_gnt`.
- `if_addr`  in  32  fetch address; stable while `if_req` is high.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle strobe; `if_rdata` is valid.
- `if_rdata`  out  32  fetched instruction word.
- `d_req`  in  1  data request; held high until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_funct3`  in  3  access size/sign, using RISC-V funct3 encoding.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle strobe; `d_rdata` is valid (loads only).
- `d_rdata`  out  32  raw memory read word.
- `mem_write_en`  out  1  memory write strobe.
- `mem_address`  out  32  memory address.
- `mem_write_data`  out  32  memory write data.
- `mem_funct3`  out  3  access size forwarded to memory.
- `mem_read_data`  in  32  memory read data.

## Operation
- FSM states:
  - IDLE: accepts new requests.
  - READ_WAIT: a read is outstanding and the latency counter is running.
- IDLE with no request: all memory outputs are 0; stay in IDLE.
- IDLE with one or more requests:
  - The winner is picked combinationally and its `gnt` is asserted in the same cycle.
  - `mem_address` and `mem_funct3` are driven from the winner combinationally.
  - Fetch is always sent with `mem_funct3 = 3'b010`.
- Granted store:
  - `mem_write_en = 1` and `mem_write_data = d_wdata` for exactly the grant cycle.
  - No `rvalid` is produced; stay in IDLE.
  - A new grant is possible on the next cycle.
- Granted read (fetch or load):
  - Latch owner, address and funct3.
  - Load counter with `READ_LATENCY - 1`.
  - Go to READ_WAIT.
- READ_WAIT:
  - `mem_address` and `mem_funct3` are driven from the latched registers and held stable.
  - `mem_write_en = 0`.
  - The counter decrements each cycle.
  - On the cycle the counter reaches 0, the owner's `rvalid` is asserted with `rdata = mem_read_data` passed through combinationally, and the FSM returns to IDLE.
  - No grants are issued while in READ_WAIT.
- A requester that drops `req` before `gnt` has no effect.
- A requester must not drop `req` in its grant cycle.
- A non-owner's `rdata` is 0 and its `rvalid` is 0.

## Timing
- Reset values: state = IDLE; counter = 0; latched registers = 0; every output = 0; priority pointer = data.
- Reset asserted mid-read: the transaction is dropped, no `rvalid` is issued, and the FSM is in IDLE on the cycle after reset releases.
- Read granted in cycle T:
  - `rvalid` is asserted in cycle T + `READ_LATENCY`.
  - The earliest next grant is in cycle T + `READ_LATENCY` + 1.
- Write granted in cycle T: the earliest next grant is in cycle T+1.
- `gnt` and `rvalid` are never asserted to both requesters in the same cycle.
- `gnt` and `rvalid` are never high together for the same requester when `READ_LATENCY` ≥ 1.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration on simultaneous requests.
  - The requester not granted last wins.
  - A 1-bit pointer is updated on every grant.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, data over fetch.
  - The pointer is not present.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, READ_WAIT);
  - the owner enum (OWN_IF, OWN_D);
  - the constant `FUNCT3_WORD = 3'b010`.
- One sub-module, `mem_arb_picker`: combinational winner selection from `if_req`, `d_req` and the pointer, plus the pointer register under the macro.
- All other logic lives in `memory_port_arbiter`.

## Test plan
- Fetch only, `READ_LATENCY = 1`: `if_req` with `if_addr = 0x100`, `mem_read_data = 0x00500093` → `if_gnt` in cycle T, `mem_address = 0x100`, `mem_funct3 = 010`; `if_rvalid = 1` and `if_rdata = 0x00500093` in T+1.
- Store: `d_req = 1`, `d_we = 1`, `d_addr = 0x200`, `d_wdata = 0xDEADBEEF`, `funct3 = 010` → `d_gnt` and `mem_write_en` high in T only, no `d_rvalid`; a fetch is granted in T+1.
- Simultaneous requests, fixed priority: `d_req` load at 0x204 and `if_req` at 0x104 → `d_gnt` first; `if_gnt` one cycle after `d_rvalid`.
- With `MEM_ARB_ROUND_ROBIN_EN`, both requests held continuously → grants alternate D, IF, D, IF.
- `READ_LATENCY = 3`, load granted in T → `mem_address` held from T through T+3, `d_rvalid` only in T+3, and a pending `if_req` is not granted before T+4.
- `rst_n` low in T+1 of a `READ_LATENCY = 3` read → no `rvalid` ever; all outputs 0 and state IDLE after release.
